// File: rtl/gsim_stream_ctrl.sv
// Stream controller around the Gauss-Seidel solver core: loads A (and b),
// sequences clear/start/done per column and streams buffered results out.
module gsim_stream_ctrl #(
   parameter int N   = 8,
   parameter int AW  = 8,
   parameter int IW  = 16,
   parameter int XW  = 32,
   parameter int OSL = 24,
   parameter int OW  = 8,
   parameter int TMO = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mode,
   input  logic [IW-1:0]     data_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OW-1:0]     data_o,
   output logic              busy,
   output logic              err,
   output logic              core_rst,
   output logic              core_start,
   output logic [N*N*AW-1:0] core_a,
   output logic [N*AW-1:0]   core_b,
   input  logic              core_done,
   input  logic [N*XW-1:0]   core_x
);

   localparam int NA    = N*N*AW/IW;
   localparam int NB    = N*AW/IW;
   localparam int ABITS = N*N*AW;
   localparam int BBITS = N*AW;
   localparam int BLK   = N*OSL;
   localparam int RBITS = N*BLK;
   localparam int BT1   = RBITS/OW;
   localparam int BT0   = BLK/OW;
   localparam int WCW   = $clog2(NA+NB+1);
   localparam int CW    = $clog2(N);
   localparam int TW    = $clog2(TMO+1);
   localparam int BCW   = $clog2(BT1+1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CLR, S_GO, S_WAIT, S_OUT
   } state_t;

   state_t state, nxt;

   logic              mode_q, err_q;
   logic              accept, mode_sel, word_last;
   logic              col_last, tmo_hit, beat_last, xfer;
   logic [WCW-1:0]    word_cnt, idx;
   logic [CW-1:0]     col;
   logic [TW-1:0]     tmo_cnt;
   logic [BCW-1:0]    beat_cnt;
   logic [RBITS-1:0]  res;
   logic [BLK-1:0]    cap;
   logic [BBITS-1:0]  unit;
   logic [ABITS+IW-1:0] a_sh;
   logic [BBITS+IW-1:0] b_sh;
   logic              unused;

   assign a_sh      = {core_a, data_i};
   assign b_sh      = {core_b, data_i};
   assign accept    = in_valid && (state == S_IDLE || state == S_LOAD);
   assign mode_sel  = (state == S_IDLE) ? mode : mode_q;
   assign idx       = (state == S_IDLE) ? '0 : word_cnt;
   assign word_last = mode_sel ? (idx == WCW'(NA-1))
                               : (idx == WCW'(NA+NB-1));
   assign col_last  = !mode_q || (col == CW'(N-1));
   assign tmo_hit   = (tmo_cnt == TW'(TMO-1));
   assign beat_last = mode_q ? (beat_cnt == BCW'(BT1-1))
                             : (beat_cnt == BCW'(BT0-1));
   assign xfer      = (state == S_OUT) && out_ready;
   assign err       = err_q;
   assign unused    = ^{a_sh[ABITS+IW-1:ABITS],
                        b_sh[BBITS+IW-1:BBITS], core_x};

   // Top OSL bits of each core element, element 0 stays in the MSBs
   always_comb begin
      cap  = '0;
      unit = '0;
      for (int e = 0; e < N; e++) begin
         cap[(N-e)*OSL-1 -: OSL] = core_x[(N-e)*XW-1 -: OSL];
         unit[(N-1-e)*AW] = (col == CW'(e));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt        = state;
      in_ready   = 1'b0;
      core_rst   = 1'b0;
      core_start = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      data_o     = '0;
      unique case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) nxt = word_last ? S_CLR : S_LOAD;
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && word_last) nxt = S_CLR;
         end
         S_CLR: begin
            core_rst = 1'b1;
            nxt      = S_GO;
         end
         S_GO: begin
            core_start = 1'b1;
            nxt        = S_WAIT;
         end
         S_WAIT: begin
            if (core_done)    nxt = col_last ? S_OUT : S_CLR;
            else if (tmo_hit) nxt = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            data_o    = res[RBITS-1 -: OW];
            if (out_ready && beat_last) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt <= '0;
         col      <= '0;
         tmo_cnt  <= '0;
         beat_cnt <= '0;
         res      <= '0;
         core_a   <= '0;
         core_b   <= '0;
         mode_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            word_cnt <= idx + 1'b1;
            if (idx < WCW'(NA)) core_a <= a_sh[ABITS-1:0];
            else                core_b <= b_sh[BBITS-1:0];
         end
         // Clearing results here makes timed-out columns stream as zero
         if (accept && state == S_IDLE) begin
            mode_q   <= mode;
            err_q    <= 1'b0;
            col      <= '0;
            beat_cnt <= '0;
            res      <= '0;
         end
         if (state == S_CLR && mode_q) core_b <= unit;
         if (state == S_GO) tmo_cnt <= '0;
         if (state == S_WAIT) begin
            if (core_done) begin
               res[RBITS-1 - int'(col)*BLK -: BLK] <= cap;
               col <= col + 1'b1;
            end else if (tmo_hit) begin
               err_q <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end
         if (xfer) begin
            res      <= res << OW;
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gsim_stream_ctrl.sv
// Directed bench for gsim_stream_ctrl with a latency core model
// and a beat scoreboard fed when each run is launched.
module tb_gsim_stream_ctrl;

   localparam int N     = 8;
   localparam int AW    = 8;
   localparam int IW    = 16;
   localparam int XW    = 32;
   localparam int OSL   = 24;
   localparam int OW    = 8;
   localparam int TMO   = 64;
   localparam int NA    = N*N*AW/IW;
   localparam int NB    = N*AW/IW;
   localparam int ABITS = N*N*AW;
   localparam int BBITS = N*AW;
   localparam int LAT   = 20;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              mode = 1'b0;
   logic [IW-1:0]     data_i = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [OW-1:0]     data_o;
   logic              busy, err, core_rst, core_start;
   logic [ABITS-1:0]  core_a;
   logic [BBITS-1:0]  core_b;
   logic              core_done = 1'b0;
   logic [N*XW-1:0]   core_x = '0;

   int total = 0;
   int bad = 0;
   int nbeat = 0;
   int bcyc = 0;
   int tmr = 0;
   bit bp = 0;
   bit run_mode = 0;
   bit core_dead = 0;
   logic [7:0] tag_m = 8'h00;
   logic [ABITS-1:0] exp_a;
   logic [8:0] exp_q[$];
   bit stall = 0;
   logic [OW-1:0] hold_d = '0;

   always #5 clk = ~clk;

   gsim_stream_ctrl #(
      .N(N), .AW(AW), .IW(IW), .XW(XW),
      .OSL(OSL), .OW(OW), .TMO(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .data_i(data_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_o(data_o), .busy(busy), .err(err),
      .core_rst(core_rst), .core_start(core_start),
      .core_a(core_a), .core_b(core_b),
      .core_done(core_done), .core_x(core_x)
   );

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] xval(input logic [7:0] tg,
                                        input int k, input int e);
      if (tg == 8'h00) return 32'h0002_0000;
      return {tg, 8'(k), 8'(e), 8'h3C};
   endfunction

   function automatic int col_of(input logic [BBITS-1:0] b);
      if (!run_mode) return 0;
      for (int i = 0; i < N; i++)
         if (b[(N-1-i)*AW +: AW] == 8'd1) return i;
      return 0;
   endfunction

   function automatic logic [N*XW-1:0] pack_x(input int k);
      logic [N*XW-1:0] x;
      x = '0;
      for (int e = 0; e < N; e++)
         x[(N-1-e)*XW +: XW] = xval(tag_m, k, e);
      return x;
   endfunction

   // Core model: answers LAT cycles after start unless told to stay silent
   always @(posedge clk) begin
      core_done <= 1'b0;
      if (reset) tmr <= 0;
      else if (core_start) tmr <= LAT;
      else if (tmr > 0) begin
         tmr <= tmr - 1;
         if (tmr == 1 && !core_dead) begin
            core_done <= 1'b1;
            core_x    <= pack_x(col_of(core_b));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      bcyc++;
      if (!bp) out_ready = 1'b1;
      else begin
         case (bcyc % 4)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (reset) stall = 0;
      else begin
         if (out_valid && stall) chk("hold", data_o, hold_d);
         if (out_valid && out_ready) begin
            nbeat++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
            chk("beat", data_o, e);
         end
         stall  = out_valid && !out_ready;
         hold_d = data_o;
      end
   end

   task automatic push_exp(input bit m, input logic [7:0] tg,
                           input bit dead);
      logic [31:0] v;
      for (int k = 0; k < (m ? N : 1); k++)
         for (int e = 0; e < N; e++) begin
            v = dead ? 32'h0 : xval(tg, k, e);
            exp_q.push_back({1'b0, v[31:24]});
            exp_q.push_back({1'b0, v[23:16]});
            exp_q.push_back({1'b0, v[15:8]});
         end
   endtask

   task automatic send_run(input bit m, input logic [7:0] dv,
                           input logic [7:0] bv, input bit keep);
      logic [ABITS-1:0] ea;
      logic [BBITS-1:0] eb;
      int nw;
      ea = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            ea[(N*N-1-(r*N+c))*AW +: AW] = (r == c) ? dv : 8'h00;
      eb = {N{bv}};
      exp_a = ea;
      run_mode = m;
      nw = m ? NA : NA+NB;
      for (int w = 0; w < nw; w++) begin
         in_valid = 1'b1;
         mode = (w == 0) ? m : !m;
         data_i = (w < NA) ? ea[ABITS-1-w*IW -: IW]
                           : eb[BBITS-1-(w-NA)*IW -: IW];
         @(posedge clk); #1;
         if (w == 0) chk("err_clr", err, 0);
      end
      if (keep) data_i = 16'hDEAD;
      else in_valid = 1'b0;
      chk("core_rst_lat", core_rst, 1);
      chk("core_a", core_a, ea);
      if (!m) chk("core_b", core_b, eb);
      @(posedge clk); #1;
      chk("core_start_lat", {core_rst, core_start}, 2'b01);
      chk("in_ready_busy", in_ready, 0);
   endtask

   task automatic wait_done(output int nst, output logic [63:0] b3,
                            output int lat);
      bit pd;
      pd = 0; nst = 1; b3 = '0; lat = -1;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (pd) chk("done_lat", core_rst | out_valid, 1);
         pd = core_done;
         if (core_start) begin
            nst++;
            if (nst == 4) b3 = core_b;
         end
         if (err && lat < 0) lat = c + 1;
         if (out_valid) in_valid = 1'b0;
         if (!busy) return;
      end
      chk("run_bound", busy, 0);
   endtask

   initial begin
      int nst, lat, b0;
      logic [63:0] b3;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_core_rst", core_rst, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_data_o", data_o, 0);
      reset = 1'b0;

      tag_m = 8'h00;
      push_exp(0, 8'h00, 0);
      b0 = nbeat;
      send_run(0, 8'd4, 8'd8, 0);
      wait_done(nst, b3, lat);
      chk("m0_starts", nst, 1);
      chk("m0_beats", nbeat - b0, 24);
      chk("m0_q", exp_q.size(), 0);
      chk("m0_busy", busy, 0);

      tag_m = 8'h11;
      push_exp(1, 8'h11, 0);
      b0 = nbeat;
      send_run(1, 8'd2, 8'd0, 1);
      wait_done(nst, b3, lat);
      chk("m1_starts", nst, 8);
      chk("m1_b_col3", b3, 64'h00000001_00000000);
      chk("m1_beats", nbeat - b0, 192);
      chk("m1_a_kept", core_a, exp_a);
      chk("m1_q", exp_q.size(), 0);

      tag_m = 8'h22;
      bp = 1;
      push_exp(1, 8'h22, 0);
      b0 = nbeat;
      send_run(1, 8'd3, 8'd0, 0);
      wait_done(nst, b3, lat);
      bp = 0;
      chk("bp_beats", nbeat - b0, 192);
      chk("bp_q", exp_q.size(), 0);

      core_dead = 1;
      push_exp(0, 8'h00, 1);
      b0 = nbeat;
      send_run(0, 8'd5, 8'd10, 0);
      wait_done(nst, b3, lat);
      core_dead = 0;
      chk("tmo_lat", lat, TMO + 1);
      chk("tmo_err_held", err, 1);
      chk("tmo_beats", nbeat - b0, 24);
      chk("tmo_q", exp_q.size(), 0);

      tag_m = 8'h33;
      push_exp(1, 8'h33, 0);
      send_run(1, 8'd2, 8'd0, 0);
      nst = 1;
      for (int c = 0; c < 2000 && nst < 6; c++) begin
         @(posedge clk); #1;
         if (core_start) nst++;
      end
      chk("rst_col5_reached", nst, 6);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_busy", busy, 0);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_core_rst", core_rst, 0);
      chk("mid_in_ready", in_ready, 1);
      chk("mid_core_a", core_a, 0);
      exp_q.delete();
      reset = 1'b0;

      tag_m = 8'h44;
      push_exp(0, 8'h44, 0);
      b0 = nbeat;
      send_run(0, 8'd6, 8'd12, 0);
      wait_done(nst, b3, lat);
      chk("re_starts", nst, 1);
      chk("re_beats", nbeat - b0, 24);
      chk("re_q", exp_q.size(), 0);
      chk("re_err", err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
